// File: rtl/dmem_pkg.sv
// Shared types for the pipelined data memory: FSM states and
// the response header carried alongside read data.
package dmem_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic valid;
        logic err;
    } rsp_hdr_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit and the data memory.
// Requests use valid/ready; responses have no backpressure.
interface dmem_if #(
    parameter int N = 32
);
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [N-1:0]   req_addr;
    logic [N-1:0]   req_wdata;
    logic [N/8-1:0] req_be;
    logic           rsp_valid;
    logic [N-1:0]   rsp_rdata;
    logic           rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_rsp_pipe.sv
// LAT-deep shift register delaying {valid, err, rdata} so every
// response appears a fixed number of cycles after acceptance.
module dmem_rsp_pipe
    import dmem_pkg::*;
#(
    parameter int N   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  rsp_hdr_t     hdr_in,
    input  logic [N-1:0] data_in,
    output rsp_hdr_t     hdr_out,
    output logic [N-1:0] data_out
);

    rsp_hdr_t     hdr_q  [LAT];
    logic [N-1:0] data_q [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                hdr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            hdr_q[0]  <= hdr_in;
            data_q[0] <= data_in;
            for (int i = 1; i < LAT; i++) begin
                hdr_q[i]  <= hdr_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign hdr_out  = hdr_q[LAT-1];
    assign data_out = data_q[LAT-1];

endmodule

// File: rtl/dmem_pipe.sv
// Byte-addressed data memory with self-clearing INIT phase,
// per-lane writes, error detection and fixed-latency responses.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int N   = 32,
    parameter int R   = 6,
    parameter int LAT = 1
) (
    input logic  clk,
    input logic  reset,
    dmem_if.slave bus
);

    localparam int NB = N / 8;
    localparam int A  = $clog2(NB);
    localparam int D  = 2 ** R;

    state_t       state;
    state_t       state_nx;
    logic [R-1:0] idx;
    logic [N-1:0] mem [D];

    logic [R-1:0] widx;
    logic         err;
    logic         acc;
    logic         wr_en;
    rsp_hdr_t     hdr;
    logic [N-1:0] rdata;
    rsp_hdr_t     hdr_o;

    assign widx  = bus.req_addr[A+R-1:A];
    assign err   = (|bus.req_addr[A-1:0]) | (|bus.req_addr[N-1:A+R]);
    assign bus.req_ready = (state == RUN) && !reset;
    assign acc   = bus.req_valid && bus.req_ready;
    assign wr_en = acc && bus.req_we && !err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT)
                idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (&idx) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    // Memory contents are not reset; INIT sweeps zeros through it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[idx] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < NB; b++)
                    if (bus.req_be[b])
                        mem[widx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        hdr.valid = acc;
        hdr.err   = acc && err;
        rdata     = '0;
        if (acc && !bus.req_we && !err)
            rdata = mem[widx];
    end

    dmem_rsp_pipe #(
        .N   (N),
        .LAT (LAT)
    ) u_rsp (
        .clk      (clk),
        .reset    (reset),
        .hdr_in   (hdr),
        .data_in  (rdata),
        .hdr_out  (hdr_o),
        .data_out (bus.rsp_rdata)
    );

    assign bus.rsp_valid = hdr_o.valid;
    assign bus.rsp_err   = hdr_o.err;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench driving LAT=1/3/4 instances with identical stimulus
// and checking each response stream against hand-computed vectors.
module tb_dmem_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } ent_t;

    ent_t q1[$];
    ent_t q3[$];
    ent_t q4[$];
    ent_t eq[$];

    always #5 clk = ~clk;

    dmem_if #(.N(32)) b1 ();
    dmem_if #(.N(32)) b3 ();
    dmem_if #(.N(32)) b4 ();

    assign b1.req_valid = valid;
    assign b1.req_we    = we;
    assign b1.req_addr  = addr;
    assign b1.req_wdata = wdata;
    assign b1.req_be    = be;
    assign b3.req_valid = valid;
    assign b3.req_we    = we;
    assign b3.req_addr  = addr;
    assign b3.req_wdata = wdata;
    assign b3.req_be    = be;
    assign b4.req_valid = valid;
    assign b4.req_we    = we;
    assign b4.req_addr  = addr;
    assign b4.req_wdata = wdata;
    assign b4.req_be    = be;

    dmem_pipe #(.N(32), .R(6), .LAT(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1));
    dmem_pipe #(.N(32), .R(6), .LAT(3)) u3 (
        .clk(clk), .reset(reset), .bus(b3));
    dmem_pipe #(.N(32), .R(6), .LAT(4)) u4 (
        .clk(clk), .reset(reset), .bus(b4));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b1.rsp_valid) q1.push_back('{cyc, b1.rsp_err, b1.rsp_rdata});
        if (b3.rsp_valid) q3.push_back('{cyc, b3.rsp_err, b3.rsp_rdata});
        if (b4.rsp_valid) q4.push_back('{cyc, b4.rsp_err, b4.rsp_rdata});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge; it is accepted on the next edge.
    task automatic req(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic e, input logic [31:0] rd);
        chk("ready_before_req", {31'b0, b1.req_ready}, 32'd1);
        valid = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = m;
        eq.push_back('{cyc + 1, e, rd});
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        valid = 1'b0;
        we    = 1'b0;
        be    = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_one(input ent_t got[$], input int lat,
                             input string tag);
        chk({tag, "_count"}, got.size(), eq.size());
        for (int i = 0; i < eq.size() && i < got.size(); i++) begin
            chk({tag, "_cycle"}, got[i].cyc, eq[i].cyc + lat - 1);
            chk({tag, "_err"}, {31'b0, got[i].err}, {31'b0, eq[i].err});
            chk({tag, "_rdata"}, got[i].rdata, eq[i].rdata);
        end
    endtask

    task automatic verify(input string tag);
        idle_n(6);
        check_one(q1, 1, {tag, "_l1"});
        check_one(q3, 3, {tag, "_l3"});
        check_one(q4, 4, {tag, "_l4"});
        q1.delete();
        q3.delete();
        q4.delete();
        eq.delete();
    endtask

    // Called at the negedge where reset has just dropped.
    task automatic init_check(input string tag);
        for (int k = 0; k <= 64; k++) begin
            #1;
            chk(tag, {29'b0, b1.req_ready, b3.req_ready, b4.req_ready},
                (k == 64) ? 32'h7 : 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {29'b0, b1.rsp_valid, b3.rsp_valid, b4.rsp_valid}, 0);
        chk("rst_err", {29'b0, b1.rsp_err, b3.rsp_err, b4.rsp_err}, 0);
        chk("rst_rdata_l1", b1.rsp_rdata, 0);
        chk("rst_rdata_l4", b4.rsp_rdata, 0);
        chk("rst_ready", {29'b0, b1.req_ready, b3.req_ready, b4.req_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        init_check("init_ready");

        for (int i = 0; i < 64; i++)
            req(1'b0, 32'(i * 4), '0, 4'h0, 1'b0, 32'h0);
        verify("zero_all");

        req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        req(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 32'h0);
        req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA);
        verify("merge");

        req(1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'h0);
        req(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0);
        req(1'b1, 32'h100, 32'h11223344, 4'hF, 1'b1, 32'h0);
        req(1'b1, 32'h11, 32'h55667788, 4'hF, 1'b1, 32'h0);
        req(1'b0, 32'h80000000, 32'h0, 4'h0, 1'b1, 32'h0);
        req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA);
        verify("errors");

        req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
        req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
        req(1'b1, 32'h20, 32'h12345678, 4'h6, 1'b0, 32'h0);
        req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h00345600);
        verify("lanes");

        for (int i = 0; i < 8; i++)
            req(1'b1, 32'(i * 4), 32'(i), 4'hF, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)
            req(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, 32'(i));
        verify("b2b");

        req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA);
        idle_n(1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("flush_l1_count", q1.size(), 1);
        chk("flush_l3_count", q3.size(), 0);
        chk("flush_l4_count", q4.size(), 0);
        q1.delete();
        q3.delete();
        q4.delete();
        eq.delete();
        init_check("reinit_ready");

        for (int i = 0; i < 64; i++)
            req(1'b0, 32'(i * 4), '0, 4'h0, 1'b0, 32'h0);
        verify("rezero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_pipe.md
DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter N, default 32, data width in bits; the design SHALL support 32 and 64.
REQ-002 Parameter R, default 6, word-index width; depth SHALL be 2**R words.
REQ-003 Parameter LAT, default 1, response latency in cycles; the design SHALL support LAT 1..4.
REQ-004 Derived constant A = log2(N/8) SHALL set the byte-offset bits; the design SHALL NOT expose A as a parameter.
REQ-005 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  N  byte address.
REQ-011 req_wdata  input  N  write data.
REQ-012 req_be  input  N/8  byte-lane write enables.
REQ-013 rsp_valid  output  1  response present; there SHALL be no backpressure.
REQ-014 rsp_rdata  output  N  read data; SHALL be 0 for write and error responses.
REQ-015 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-016 FSM states SHALL be INIT and RUN.
REQ-017 In INIT, one word per cycle SHALL be zeroed at index 0..2**R-1, ascending.
REQ-018 INIT SHALL move to RUN after index 2**R-1; this SHALL take exactly 2**R cycles.
REQ-019 req_ready SHALL be high only in RUN.
REQ-020 A request SHALL be accepted on the edge where req_valid and req_ready are both high.
REQ-021 Word index SHALL be req_addr[A+R-1:A].
REQ-022 Misaligned: req_addr[A-1:0] != 0 SHALL set error.
REQ-023 Out of range: any bit of req_addr[N-1:A+R] set SHALL set error.
REQ-024 An error request SHALL NOT modify memory.
REQ-025 Write: each byte lane with req_be set SHALL update at the accept edge; other lanes SHALL hold.
REQ-026 A write with req_be = 0 SHALL be a legal no-op and SHALL get a response.
REQ-027 Read data SHALL be memory contents at the accept edge.
REQ-028 A read accepted the cycle after a write to the same word SHALL return the written data.
REQ-029 Every accepted request SHALL produce exactly one response with rsp_valid high exactly LAT cycles after acceptance.
REQ-030 Responses SHALL return in acceptance order.
REQ-031 Back-to-back requests, one per cycle, SHALL be sustained indefinitely.

Reset
REQ-032 While reset is high: state SHALL go to INIT, INIT index SHALL be 0, and the response pipeline SHALL be flushed.
REQ-033 Reset values SHALL be: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-034 Reset asserted mid-operation SHALL drop all in-flight responses and restart INIT from index 0.
REQ-035 The first cycle after reset deasserts SHALL be INIT cycle 0.

Structure
REQ-036 Package dmem_pkg SHALL hold the state enum (INIT, RUN) and response-field struct typedef.
REQ-037 Sub-module dmem_rsp_pipe SHALL hold the LAT-stage shift register for {valid, err, rdata}, with synchronous flush.
REQ-038 Memory SHALL be a single array of 2**R words of N bits.

Verification
REQ-039 Reset, then 64 idle cycles -> req_ready 0 through cycle 63, 1 at cycle 64; a read of every word returns 0.
REQ-040 Write 0xDEADBEEF @0x10 be=0xF, then write 0x000000AA @0x10 be=0x1, then read @0x10 -> 0xDEADBEAA, rsp_err 0, LAT=1 and LAT=3.
REQ-041 Read @0x13 and read @0x100 (N=32, R=6) -> rsp_err 1, rsp_rdata 0; a following read @0x0 shows memory unchanged.
REQ-042 Back-to-back: writes of i to words 0..7, then reads of words 0..7 -> 16 responses, one per cycle, reads return 0..7 in order.
REQ-043 Reset asserted 2 cycles after a read is accepted with LAT=4 -> no rsp_valid pulse; INIT restarts; all words read back 0.
